// File: rtl/cmp_scheduler.sv
// cmp_scheduler
// Round-robin arbiter in front of one shared bit-serial magnitude comparator.
// The granted requester's operands are latched and compared MSB-first, one bit
// per cycle, stopping at the first unequal bit.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset
//   req            per-requester request level
//   a_flat/b_flat  operands, requester i at [i*WIDTH +: WIDTH]
//   gnt            one-hot, one-cycle grant pulse (operands latched on the same edge)
//   done           one-hot, one-cycle completion pulse to the served requester
//   less_than/equal_to/greater_than  result of the last completed comparison
//   busy           high while a comparison is in flight (COMPARE and RESULT)
//   bits_evaluated bits examined by the last completed comparison
module cmp_scheduler #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ*WIDTH-1:0]          a_flat,
  input  logic [NREQ*WIDTH-1:0]          b_flat,
  output logic [NREQ-1:0]                gnt,
  output logic [NREQ-1:0]                done,
  output logic                           less_than,
  output logic                           equal_to,
  output logic                           greater_than,
  output logic                           busy,
  output logic [$clog2(WIDTH+1)-1:0]     bits_evaluated
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, COMPARE, RESULT} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win_q, win_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [XW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_d, done_d;
  logic             lt_d, eq_d, gt_d, busy_d;
  logic [CW-1:0]    bits_d;

  logic             found;
  logic [IW-1:0]    pick;
  int unsigned      cand;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    done_d  = '0;
    lt_d    = less_than;
    eq_d    = equal_to;
    gt_d    = greater_than;
    bits_d  = bits_evaluated;
    found   = 1'b0;
    pick    = '0;
    cand    = 0;

    // Round-robin search starting just after the last served requester
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = (int'(ptr_q) + i) % NREQ;
      if (!found && req[IW'(cand)]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          gnt_d   = NREQ'(1) << pick;
          a_d     = a_flat[int'(pick)*WIDTH +: WIDTH];
          b_d     = b_flat[int'(pick)*WIDTH +: WIDTH];
          idx_d   = XW'(WIDTH - 1);
          cnt_d   = '0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        cnt_d = cnt_q + CW'(1);
        if (a_q[idx_q] != b_q[idx_q]) begin
          lt_d    = b_q[idx_q];
          gt_d    = a_q[idx_q];
          eq_d    = 1'b0;
          bits_d  = cnt_q + CW'(1);
          done_d  = NREQ'(1) << win_q;
          state_d = RESULT;
        end else if (idx_q == '0) begin
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          bits_d  = cnt_q + CW'(1);
          done_d  = NREQ'(1) << win_q;
          state_d = RESULT;
        end else begin
          idx_d = idx_q - XW'(1);
        end
      end
      RESULT: begin
        // No arbitration here; the served index becomes the new priority pointer
        ptr_d   = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      ptr_q          <= IW'(NREQ - 1);
      win_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      idx_q          <= '0;
      cnt_q          <= '0;
      gnt            <= '0;
      done           <= '0;
      less_than      <= 1'b0;
      equal_to       <= 1'b0;
      greater_than   <= 1'b0;
      busy           <= 1'b0;
      bits_evaluated <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      win_q          <= win_d;
      a_q            <= a_d;
      b_q            <= b_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      gnt            <= gnt_d;
      done           <= done_d;
      less_than      <= lt_d;
      equal_to       <= eq_d;
      greater_than   <= gt_d;
      busy           <= busy_d;
      bits_evaluated <= bits_d;
    end
  end

endmodule
